// File: rtl/cpm68k_mem_pkg.sv
// Shared constants and request bundle for the cpm68k single-port byte RAM.
// The RAM returns read data one cycle after the access.
package cpm68k_mem_pkg;
  localparam int SPRAM_AW     = 6;
  localparam int SPRAM_DW     = 8;
  localparam int SPRAM_DEPTH  = 64;
  localparam int SPRAM_RD_LAT = 1;

  typedef struct packed {
    logic                ce;
    logic                wre;
    logic [SPRAM_AW-1:0] ad;
    logic [SPRAM_DW-1:0] din;
  } spram_req_t;
endpackage

// File: rtl/sp_fifo_ctrl_if.sv
// Byte stream and RAM port bundle of the single-port FIFO controller.
// The slave modport is the controller's view.
interface sp_fifo_ctrl_if import cpm68k_mem_pkg::*; #(
  parameter int DW = SPRAM_DW,
  parameter int AW = SPRAM_AW,
  parameter int CW = 7
);
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] count;
  logic          ram_ce;
  logic          ram_oce;
  logic          ram_reset;
  logic          ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  wr_data, wr_valid, rd_ready, ram_dout,
    output wr_ready, rd_data, rd_valid, count,
    output ram_ce, ram_oce, ram_reset, ram_wre, ram_ad, ram_din
  );

  modport master (
    output wr_data, wr_valid, rd_ready, ram_dout,
    input  wr_ready, rd_data, rd_valid, count,
    input  ram_ce, ram_oce, ram_reset, ram_wre, ram_ad, ram_din
  );
endinterface

// File: rtl/sp_fifo_obuf.sv
// Two-entry output buffer behind the RAM read port; entry 0 is the head.
// The head keeps its last value when the buffer empties.
module sp_fifo_obuf import cpm68k_mem_pkg::*; #(
  parameter int DW = SPRAM_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  output logic [1:0]    cnt_o
);
  logic [DW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]    cnt_q, cnt_d;

  // Next-state of the two entries and fill level
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ent0_d = '0;
      ent1_d = '0;
      cnt_d  = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push_i) begin
            ent0_d = din_i;
            cnt_d  = 2'd1;
          end else begin
            cnt_d = 2'd0;
          end
        end
        2'd1: begin
          case ({push_i, pop_i})
            2'b11:   ent0_d = din_i;
            2'b10: begin
              ent1_d = din_i;
              cnt_d  = 2'd2;
            end
            2'b01:   cnt_d = 2'd0;
            default: cnt_d = 2'd1;
          endcase
        end
        2'd2: begin
          // A push while full is only possible together with a pop
          if (pop_i) begin
            ent0_d = ent1_q;
            if (push_i) begin
              ent1_d = din_i;
              cnt_d  = 2'd2;
            end else begin
              cnt_d = 2'd1;
            end
          end else begin
            cnt_d = 2'd2;
          end
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  // Entry and fill-level registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = ent0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/sp_fifo_ctrl.sv
// Byte FIFO built on a 64x8 single-port RAM: one access per cycle, reads
// prefetched into a 2-entry output buffer, writes fill the remaining slots.
module sp_fifo_ctrl import cpm68k_mem_pkg::*; #(
  parameter int DW    = SPRAM_DW,
  parameter int AW    = SPRAM_AW,
  parameter int DEPTH = SPRAM_DEPTH,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  sp_fifo_ctrl_if.slave bus
);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C  = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;

  logic          act_s, rd_elig_s, rd_pri_s, rd_iss_s, wr_rdy_s, wr_acc_s;
  logic          push_s, pop_s, ob_valid_s;
  logic [1:0]    ob_cnt_s, occ_s;
  logic [DW-1:0] ob_dout_s;
  spram_req_t    req_s;

  // Port arbitration; reset low or flush blocks every access immediately
  always_comb begin
    act_s     = reset_n & ~flush;
    occ_s     = ob_cnt_s + {1'b0, inflight_q};
    rd_elig_s = (ram_cnt_q != '0) && (occ_s < 2'd2);
    rd_pri_s  = rd_elig_s && (occ_s == 2'd0);
    rd_iss_s  = act_s && rd_elig_s &&
                (rd_pri_s || !bus.wr_valid || (ram_cnt_q == FULL_C));
    wr_rdy_s  = act_s && (ram_cnt_q < FULL_C) && !rd_iss_s;
    wr_acc_s  = wr_rdy_s && bus.wr_valid;
    push_s    = inflight_q && !flush;
    pop_s     = ob_valid_s && bus.rd_ready && !flush;
  end

  // RAM request for this cycle; address and data are zero when idle
  always_comb begin
    req_s = '0;
    if (rd_iss_s) begin
      req_s.ce  = 1'b1;
      req_s.wre = 1'b0;
      req_s.ad  = rd_ptr_q;
    end else if (wr_acc_s) begin
      req_s.ce  = 1'b1;
      req_s.wre = 1'b1;
      req_s.ad  = wr_ptr_q;
      req_s.din = bus.wr_data;
    end else begin
      req_s = '0;
    end
  end

  // Pointer, occupancy and in-flight tracking
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      count_d   = '0;
    end else begin
      wr_ptr_d   = wr_ptr_q + AW'(wr_acc_s);
      rd_ptr_d   = rd_ptr_q + AW'(rd_iss_s);
      inflight_d = rd_iss_s;
      case ({wr_acc_s, rd_iss_s})
        2'b10:   ram_cnt_d = ram_cnt_q + ONE_C;
        2'b01:   ram_cnt_d = ram_cnt_q - ONE_C;
        default: ram_cnt_d = ram_cnt_q;
      endcase
      count_d = count_q + CW'(wr_acc_s) - CW'(pop_s);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  sp_fifo_obuf #(.DW(DW)) u_obuf (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push_i  (push_s),
    .din_i   (bus.ram_dout),
    .pop_i   (pop_s),
    .dout_o  (ob_dout_s),
    .valid_o (ob_valid_s),
    .cnt_o   (ob_cnt_s)
  );

  assign bus.wr_ready  = wr_rdy_s;
  assign bus.rd_data   = ob_dout_s;
  assign bus.rd_valid  = ob_valid_s;
  assign bus.count     = count_q;
  assign bus.ram_ce    = req_s.ce;
  assign bus.ram_wre   = req_s.wre;
  assign bus.ram_ad    = req_s.ad;
  assign bus.ram_din   = req_s.din;
  assign bus.ram_oce   = 1'b1;
  assign bus.ram_reset = 1'b0;
endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Bench for sp_fifo_ctrl: behavioural RAM plus a queue-based FIFO model that
// predicts every cycle's handshake, RAM request and output from the arbitration rules.
module tb_sp_fifo_ctrl;
  import cpm68k_mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  sp_fifo_ctrl_if bus ();
  sp_fifo_ctrl dut (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus));

  logic [7:0] mem [0:63];
  logic [7:0] dout_r;
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_din;
      else dout_r <= mem[bus.ram_ad];
    end
  end
  assign bus.ram_dout = dout_r;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes in RAM, the byte being read, the output buffer
  logic [7:0] m_ram[$];
  logic [7:0] m_ob[$];
  bit         m_infl;
  logic [7:0] m_infl_b;
  int         m_wptr, m_rptr;

  bit         e_wrdy, e_ce, e_wre, e_rvalid;
  logic [5:0] e_ad;
  logic [7:0] e_din, e_rdata;
  int         e_count;
  logic       o_wrdy, o_ce, o_wre, o_rvalid;
  logic [5:0] o_ad;
  logic [7:0] o_din, o_rdata;
  logic [6:0] o_count;
  logic [34:0] rst_vec, rst_exp;

  task automatic model_reset();
    m_ram.delete();
    m_ob.delete();
    m_infl = 1'b0;
    m_wptr = 0;
    m_rptr = 0;
  endtask

  // Applies one cycle of stimulus, records prediction and DUT outputs, advances the model
  task automatic step(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
    bit elig, pri, rdis, pop;
    int occ;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    flush        = fl;
    @(negedge clk);
    occ      = m_ob.size() + int'(m_infl);
    elig     = (m_ram.size() > 0) && (occ < 2);
    pri      = elig && (occ == 0);
    rdis     = !fl && elig && (pri || !wv || m_ram.size() == 64);
    e_wrdy   = !fl && (m_ram.size() < 64) && !rdis;
    e_wre    = e_wrdy && wv;
    e_ce     = rdis || e_wre;
    e_ad     = rdis ? 6'(m_rptr) : 6'(m_wptr);
    e_din    = wd;
    e_rvalid = m_ob.size() > 0;
    e_rdata  = e_rvalid ? m_ob[0] : 8'h00;
    e_count  = m_ram.size() + occ;
    pop      = e_rvalid && rr && !fl;
    o_wrdy = bus.wr_ready; o_ce = bus.ram_ce; o_wre = bus.ram_wre; o_ad = bus.ram_ad;
    o_din = bus.ram_din; o_rvalid = bus.rd_valid; o_rdata = bus.rd_data; o_count = bus.count;
    if (fl) begin
      model_reset();
    end else begin
      if (pop) void'(m_ob.pop_front());
      if (m_infl) m_ob.push_back(m_infl_b);
      m_infl = rdis;
      if (rdis) begin
        m_infl_b = m_ram.pop_front();
        m_rptr = (m_rptr + 1) % 64;
      end
      if (e_wre) begin
        m_ram.push_back(wd);
        m_wptr = (m_wptr + 1) % 64;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_valid = 1'b1; bus.wr_data = 8'hFF; bus.rd_ready = 1'b1; flush = 1'b0;
    #12;
    rst_exp = {2'b00, 8'h00, 7'h00, 2'b00, 6'h00, 8'h00, 2'b10};
    rst_vec = {bus.wr_ready, bus.rd_valid, bus.rd_data, bus.count, bus.ram_ce, bus.ram_wre,
               bus.ram_ad, bus.ram_din, bus.ram_oce, bus.ram_reset};
    n_checks++;
    if (rst_vec !== rst_exp) begin n_errors++; $display("FAIL reset_outputs got %h exp %h", rst_vec, rst_exp); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_byte();
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    n_checks++;
    if ({o_ce, o_wre, o_ad, o_din} !== {2'b11, 6'd0, 8'hA5}) begin n_errors++;
      $display("FAIL first_write got ce%b wre%b ad%0d din%h exp ce1 wre1 ad0 dinA5", o_ce, o_wre, o_ad, o_din); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({o_ce, o_wre, o_ad} !== {2'b10, 6'd0}) begin n_errors++;
      $display("FAIL first_read got ce%b wre%b ad%0d exp ce1 wre0 ad0", o_ce, o_wre, o_ad); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({o_rvalid, o_rdata} !== {1'b1, 8'hA5}) begin n_errors++;
      $display("FAIL first_out got v%b d%h exp v1 dA5", o_rvalid, o_rdata); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({o_rvalid, o_count} !== {1'b0, 7'd0}) begin n_errors++;
      $display("FAIL first_empty got v%b count%0d exp v0 count0", o_rvalid, o_count); end
  endtask

  task automatic test_fill(output int accepted);
    logic [7:0] d = 8'h00;
    accepted = 0;
    for (int i = 0; i < 90; i++) begin
      step(1'b1, d, 1'b0, 1'b0);
      n_checks++;
      if (o_wrdy !== e_wrdy) begin n_errors++; $display("FAIL fill_wr_ready cyc %0d got %b exp %b", i, o_wrdy, e_wrdy); end
      n_checks++;
      if (o_count !== 7'(e_count)) begin n_errors++; $display("FAIL fill_count cyc %0d got %0d exp %0d", i, o_count, e_count); end
      if (o_wrdy) begin d++; accepted++; end
    end
    n_checks++;
    if (accepted != 66 || o_count !== 7'd66 || o_wrdy !== 1'b0) begin n_errors++;
      $display("FAIL fill_full got acc%0d count%0d rdy%b exp acc66 count66 rdy0", accepted, o_count, o_wrdy); end
  endtask

  task automatic test_drain_wrap(input int start);
    logic [7:0] d = 8'(start);
    int nxt = 0;
    for (int i = 0; i < 300; i++) begin
      step(i < 200, d, 1'b1, 1'b0);
      if (o_wrdy && i < 200) d++;
      if (o_rvalid) begin
        n_checks++;
        if (o_rdata !== 8'(nxt)) begin n_errors++; $display("FAIL wrap_order pop %0d got %h exp %h", nxt, o_rdata, 8'(nxt)); end
        nxt++;
      end
      n_checks++;
      if (o_count !== 7'(e_count)) begin n_errors++; $display("FAIL wrap_count cyc %0d got %0d exp %0d", i, o_count, e_count); end
    end
    n_checks++;
    if (nxt != int'(d) - 0 + (int'(d) < start ? 256 : 0) || o_count !== 7'd0) begin n_errors++;
      $display("FAIL wrap_total got pops%0d count%0d exp pops%0d count0", nxt, o_count, int'(d)); end
  endtask

  task automatic test_rd_pri();
    logic [4:0] pat = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      n_checks++;
      if (o_wrdy !== pat[i]) begin n_errors++; $display("FAIL rd_pri_wr_ready cyc %0d got %b exp %b", i, o_wrdy, pat[i]); end
    end
  endtask

  task automatic test_flush();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({o_ce, o_wre, o_count} !== {2'b10, 7'd4}) begin n_errors++;
      $display("FAIL flush_setup got ce%b wre%b count%0d exp ce1 wre0 count4", o_ce, o_wre, o_count); end
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    n_checks++;
    if ({o_wrdy, o_ce} !== 2'b00) begin n_errors++; $display("FAIL flush_block got rdy%b ce%b exp 00", o_wrdy, o_ce); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({o_rvalid, o_count} !== {1'b0, 7'd0}) begin n_errors++;
      $display("FAIL flush_clear got v%b count%0d exp v0 count0", o_rvalid, o_count); end
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    n_checks++;
    if ({o_wre, o_ad} !== {1'b1, 6'd0}) begin n_errors++; $display("FAIL flush_ptr got wre%b ad%0d exp wre1 ad0", o_wre, o_ad); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({o_rvalid, o_rdata} !== {1'b1, 8'h5A}) begin n_errors++;
      $display("FAIL flush_first got v%b d%h exp v1 d5A", o_rvalid, o_rdata); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    rst_vec = {bus.wr_ready, bus.rd_valid, bus.rd_data, bus.count, bus.ram_ce, bus.ram_wre,
               bus.ram_ad, bus.ram_din, bus.ram_oce, bus.ram_reset};
    n_checks++;
    if (rst_vec !== rst_exp) begin n_errors++; $display("FAIL async_reset got %h exp %h", rst_vec, rst_exp); end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++;
    if ({o_wre, o_ad, o_count} !== {1'b1, 6'd0, 7'd0}) begin n_errors++;
      $display("FAIL restart_write got wre%b ad%0d count%0d exp wre1 ad0 count0", o_wre, o_ad, o_count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({o_rvalid, o_rdata} !== {1'b1, 8'h77}) begin n_errors++;
      $display("FAIL restart_out got v%b d%h exp v1 d77", o_rvalid, o_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 59) == 0);
      n_checks++;
      if (o_wrdy !== e_wrdy) begin n_errors++; $display("FAIL rnd_wr_ready cyc %0d got %b exp %b", i, o_wrdy, e_wrdy); end
      n_checks++;
      if ({o_ce, o_wre} !== {e_ce, e_wre}) begin n_errors++;
        $display("FAIL rnd_ram_op cyc %0d got ce%b wre%b exp ce%b wre%b", i, o_ce, o_wre, e_ce, e_wre); end
      if (e_ce) begin
        n_checks++;
        if (o_ad !== e_ad) begin n_errors++; $display("FAIL rnd_ram_ad cyc %0d got %0d exp %0d", i, o_ad, e_ad); end
      end
      if (e_wre) begin
        n_checks++;
        if (o_din !== e_din) begin n_errors++; $display("FAIL rnd_ram_din cyc %0d got %h exp %h", i, o_din, e_din); end
      end
      n_checks++;
      if (o_rvalid !== e_rvalid) begin n_errors++; $display("FAIL rnd_rd_valid cyc %0d got %b exp %b", i, o_rvalid, e_rvalid); end
      if (e_rvalid) begin
        n_checks++;
        if (o_rdata !== e_rdata) begin n_errors++; $display("FAIL rnd_rd_data cyc %0d got %h exp %h", i, o_rdata, e_rdata); end
      end
      n_checks++;
      if (o_count !== 7'(e_count)) begin n_errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, o_count, e_count); end
    end
  endtask

  initial begin
    int acc;
    test_reset();
    test_first_byte();
    test_fill(acc);
    test_drain_wrap(acc);
    test_rd_pri();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
